// File: rtl/ahblite_decode_mux.sv
// Single-master AHB-Lite address decoder and response mux with an internal ERROR default slave.
// Optional AHB_DECODE_ERR_CAPTURE_EN adds ERR_CLR/ERR_FLAG/ERR_ADDR decode-error capture.
module ahblite_decode_mux #(
    parameter logic [3:0] S0_REGION = 4'h0,
    parameter logic [3:0] S1_REGION = 4'h2,
    parameter logic [3:0] S2_REGION = 4'h4,
    parameter logic [3:0] S3_REGION = 4'h5
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic [31:0]  HADDR,
    input  logic [1:0]   HTRANS,
    output logic         HREADY,
    output logic [31:0]  HRDATA,
    output logic [1:0]   HRESP,
    output logic [3:0]   HSEL_S,
    input  logic [3:0]   HREADYOUT_S,
    input  logic [127:0] HRDATA_S,
    input  logic [7:0]   HRESP_S
`ifdef AHB_DECODE_ERR_CAPTURE_EN
    ,
    input  logic         ERR_CLR,
    output logic         ERR_FLAG,
    output logic [31:0]  ERR_ADDR
`endif
);
    localparam int NUM_SLV = 4;

    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    logic [NUM_SLV-1:0][3:0]  region;
    logic [NUM_SLV-1:0][31:0] rdata_s;
    logic [NUM_SLV-1:0][1:0]  resp_s;
    logic [NUM_SLV:0]         dec;
    logic [NUM_SLV:0]         dsel;
    logic [1:0]               ds_state;
    logic [1:0]               ds_next;
    logic                     err_accept;

    assign region  = {S3_REGION, S2_REGION, S1_REGION, S0_REGION};
    assign rdata_s = HRDATA_S;
    assign resp_s  = HRESP_S;

    // Lowest index claims overlapping regions; the top bit is the default slave.
    always_comb begin
        dec = '0;
        for (int n = 0; n < NUM_SLV; n++)
            if (dec == '0 && HADDR[31:28] == region[n]) dec[n] = 1'b1;
        if (dec == '0) dec[NUM_SLV] = 1'b1;
    end

    assign HSEL_S     = dec[NUM_SLV-1:0];
    assign err_accept = HREADY & HTRANS[1] & dec[NUM_SLV];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            dsel <= '0;
        else if (HREADY)
            dsel <= dec;
    end

    // ERR2 either retires the error or chains straight into the next unmapped access.
    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if (err_accept) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = err_accept ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            ds_state <= DS_IDLE;
        else
            ds_state <= ds_next;
    end

    always_comb begin
        HREADY = 1'b1;
        HRDATA = '0;
        HRESP  = RESP_OKAY;
        for (int n = 0; n < NUM_SLV; n++) begin
            if (dsel[n]) begin
                HREADY = HREADYOUT_S[n];
                HRDATA = rdata_s[n];
                HRESP  = resp_s[n];
            end
        end
        if (dsel[NUM_SLV]) begin
            HREADY = (ds_state != DS_ERR1);
            HRESP  = (ds_state == DS_IDLE) ? RESP_OKAY : RESP_ERROR;
        end
    end

`ifdef AHB_DECODE_ERR_CAPTURE_EN
    // A new capture outranks a clear in the same cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_FLAG <= 1'b0;
            ERR_ADDR <= '0;
        end else if (err_accept) begin
            ERR_FLAG <= 1'b1;
            ERR_ADDR <= HADDR;
        end else if (ERR_CLR) begin
            ERR_FLAG <= 1'b0;
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{HADDR[27:0], HTRANS[0]};

endmodule

// File: tb/tb_ahblite_decode_mux.sv
// Scoreboard bench for ahblite_decode_mux: a transfer-level model predicts each cycle's response,
// a negedge monitor pops and compares. Define AHB_DECODE_ERR_CAPTURE_EN to also check capture.
module tb_ahblite_decode_mux;
    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic [31:0]  HRDATA;
    logic [1:0]   HRESP;
    logic [3:0]   HSEL_S;
    logic [3:0]   HREADYOUT_S;
    logic [127:0] HRDATA_S;
    logic [7:0]   HRESP_S;
`ifdef AHB_DECODE_ERR_CAPTURE_EN
    logic         ERR_CLR;
    logic         ERR_FLAG;
    logic [31:0]  ERR_ADDR;
`endif

    ahblite_decode_mux dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HSEL_S(HSEL_S),
        .HREADYOUT_S(HREADYOUT_S), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S)
`ifdef AHB_DECODE_ERR_CAPTURE_EN
        , .ERR_CLR(ERR_CLR), .ERR_FLAG(ERR_FLAG), .ERR_ADDR(ERR_ADDR)
`endif
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        int          waits;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          cancel;
    } xfer_t;

    typedef struct {
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [3:0]  hsel;
        logic        flag;
        logic [31:0] eaddr;
    } exp_t;

    xfer_t       plan_q[$];
    exp_t        exp_q[$];
    xfer_t       a_x, d_x, idle_x;
    bit          d_vld;
    int          cnt;
    logic        exp_rdy;
    logic        m_flag;
    logic [31:0] m_eaddr;
    logic        clr_d;
    bit          mon_en = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    // Memory map: region nibble -> slave index, -1 for unmapped space.
    function automatic int slave_of(logic [31:0] a);
        case (a[31:28])
            4'h0:    return 0;
            4'h2:    return 1;
            4'h4:    return 2;
            4'h5:    return 3;
            default: return -1;
        endcase
    endfunction

    function automatic xfer_t mk(logic [31:0] a, logic [1:0] t, int w, logic [31:0] d,
                                 logic [1:0] r, bit c);
        xfer_t x;
        x.addr = a; x.trans = t; x.waits = w; x.data = d; x.resp = r; x.cancel = c;
        return x;
    endfunction

    function automatic xfer_t rnd_x();
        logic [3:0] rg;
        logic [1:0] t;
        int         k;
        case ($urandom_range(0, 7))
            0: rg = 4'h0;  1: rg = 4'h2;  2: rg = 4'h4;  3: rg = 4'h5;
            4: rg = 4'h1;  5: rg = 4'h9;  6: rg = 4'hF;  default: rg = 4'h3;
        endcase
        k = $urandom_range(0, 7);
        t = (k < 4) ? 2'b10 : (k < 6) ? 2'b11 : (k == 6) ? 2'b00 : 2'b01;
        return mk({rg, 28'($urandom)}, t, t[1] ? $urandom_range(0, 2) : 0,
                  $urandom, 2'($urandom_range(0, 1)), 1'b1);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // One bus cycle: advance the model, drive master and slaves, push the expectation.
    task automatic step();
        int   s, sa;
        bit   cap;
        exp_t e;
        @(posedge HCLK);
        #1;
        cap = exp_rdy && a_x.trans[1] && (slave_of(a_x.addr) < 0);
        if (cap) begin
            m_flag  = 1'b1;
            m_eaddr = a_x.addr;
        end else if (clr_d) begin
            m_flag = 1'b0;
        end
        if (exp_rdy) begin
            d_x = a_x; d_vld = 1; cnt = 0;
            if (plan_q.size() > 0) a_x = plan_q.pop_front();
            else a_x = idle_x;
        end else begin
            cnt++;
            if (a_x.cancel && d_vld && d_x.trans[1] && slave_of(d_x.addr) < 0 && cnt == 1
                && $urandom_range(0, 1) == 1) begin
                a_x.trans = 2'b00;
                a_x.waits = 0;
            end
        end
        HADDR  = a_x.addr;
        HTRANS = a_x.trans;
`ifdef AHB_DECODE_ERR_CAPTURE_EN
        ERR_CLR = ($urandom_range(0, 7) == 0);
        clr_d   = ERR_CLR;
`endif
        for (int n = 0; n < 4; n++) begin
            HREADYOUT_S[n]       = 1'($urandom_range(0, 1));
            HRDATA_S[32*n +: 32] = $urandom;
            HRESP_S[2*n +: 2]    = 2'($urandom_range(0, 3));
        end
        s = d_vld ? slave_of(d_x.addr) : -1;
        if (s >= 0) begin
            HREADYOUT_S[s]       = (cnt >= d_x.waits);
            HRDATA_S[32*s +: 32] = d_x.data;
            HRESP_S[2*s +: 2]    = (cnt >= d_x.waits) ? d_x.resp : 2'b00;
        end
        e.hsel = 4'b0000;
        sa = slave_of(a_x.addr);
        if (sa >= 0) e.hsel[sa] = 1'b1;
        if (!d_vld) begin
            e.rdy = 1'b1; e.resp = 2'b00; e.rdata = '0;
        end else if (s >= 0) begin
            e.rdy = (cnt >= d_x.waits); e.resp = e.rdy ? d_x.resp : 2'b00; e.rdata = d_x.data;
        end else if (d_x.trans[1]) begin
            e.rdy = (cnt != 0); e.resp = 2'b01; e.rdata = '0;
        end else begin
            e.rdy = 1'b1; e.resp = 2'b00; e.rdata = '0;
        end
        e.flag  = m_flag;
        e.eaddr = m_eaddr;
        exp_rdy = e.rdy;
        exp_q.push_back(e);
    endtask

    always @(negedge HCLK) begin
        exp_t e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hready", 32'(HREADY), 32'(e.rdy));
            chk("hresp", 32'(HRESP), 32'(e.resp));
            chk("hrdata", HRDATA, e.rdata);
            chk("hsel", 32'(HSEL_S), 32'(e.hsel));
`ifdef AHB_DECODE_ERR_CAPTURE_EN
            chk("err_flag", 32'(ERR_FLAG), 32'(e.flag));
            chk("err_addr", ERR_ADDR, e.eaddr);
`endif
        end
    end

    initial begin
        int guard;
        HADDR = '0; HTRANS = 2'b00; HREADYOUT_S = '1; HRDATA_S = '0; HRESP_S = '0;
`ifdef AHB_DECODE_ERR_CAPTURE_EN
        ERR_CLR = 1'b0;
`endif
        clr_d = 0; m_flag = 0; m_eaddr = '0; d_vld = 0; cnt = 0; exp_rdy = 1'b1;
        idle_x = mk(32'h0000_0000, 2'b00, 0, 32'h0, 2'b00, 1'b0);

        plan_q.push_back(mk(32'h0000_0010, 2'b10, 0, 32'h1234_5678, 2'b00, 0));
        plan_q.push_back(mk(32'h2000_0004, 2'b10, 1, 32'h0BAD_F00D, 2'b00, 0));
        plan_q.push_back(mk(32'h0000_0020, 2'b10, 0, 32'hCAFE_0001, 2'b00, 0));
        plan_q.push_back(mk(32'h9000_0000, 2'b10, 0, 32'h0, 2'b00, 0));
        plan_q.push_back(mk(32'h4000_0000, 2'b10, 0, 32'h4444_0000, 2'b00, 0));
        plan_q.push_back(mk(32'h9000_0000, 2'b10, 0, 32'h0, 2'b00, 0));
        plan_q.push_back(mk(32'hF000_0008, 2'b11, 0, 32'h0, 2'b00, 0));
        plan_q.push_back(mk(32'h9000_0000, 2'b00, 0, 32'h0, 2'b00, 0));
        plan_q.push_back(mk(32'h5000_0040, 2'b10, 2, 32'h5555_AAAA, 2'b01, 0));
        repeat (400) plan_q.push_back(rnd_x());

        a_x = plan_q.pop_front();
        HADDR = a_x.addr; HTRANS = a_x.trans;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_hsel", 32'(HSEL_S), 32'b0001);
`ifdef AHB_DECODE_ERR_CAPTURE_EN
        chk("rst_err_flag", 32'(ERR_FLAG), 32'd0);
        chk("rst_err_addr", ERR_ADDR, 32'd0);
`endif
        @(negedge HCLK);
        HRESETn = 1'b1;
        mon_en  = 1;

        guard = 0;
        while (plan_q.size() > 0 && guard < 5000) begin step(); guard++; end

        // Reset pulse in the middle of a slave-2 wait state.
        plan_q.push_back(mk(32'h4000_0100, 2'b10, 4, 32'hA5A5_0001, 2'b00, 0));
        guard = 0;
        while (!(d_vld && slave_of(d_x.addr) == 2 && cnt == 1) && guard < 50) begin
            step(); guard++;
        end
        chk("reach_s2_wait", 32'(guard < 50), 32'd1);
        mon_en = 0;
        #2 HRESETn = 1'b0;
        #1;
        chk("midrst_hready", 32'(HREADY), 32'd1);
        chk("midrst_hresp", 32'(HRESP), 32'd0);
        chk("midrst_hrdata", HRDATA, 32'd0);
`ifdef AHB_DECODE_ERR_CAPTURE_EN
        chk("midrst_err_flag", 32'(ERR_FLAG), 32'd0);
`endif
        HRESETn = 1'b1;
        exp_q.delete();
        d_vld = 0; cnt = 0; exp_rdy = 1'b1; m_flag = 0; m_eaddr = '0;
        mon_en = 1;

        repeat (40) plan_q.push_back(rnd_x());
        guard = 0;
        while (plan_q.size() > 0 && guard < 500) begin step(); guard++; end
        repeat (4) step();
        @(negedge HCLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
